// File: rtl/rgb_lat_ctrl.sv
// rgb_lat_ctrl: aligns rgb with VGA timing through a programmable extra delay.
// Timing signals are registered once. rgb runs through a MAX_LAT+1 stage
// delay line and is tapped at 1+cur_lat cycles. A new latency is requested
// over a four-phase req/ack handshake. It is applied only at frame start and
// is followed by a blanked flush, so a frame is never torn.
// Optional build macro RGB_LAT_CTRL_BLANK_EN: when defined, rgb is also
// forced to 0 while the registered hblnk or vblnk is high.
module rgb_lat_ctrl #(
  parameter int unsigned MAX_LAT   = 4,
  parameter int unsigned RESET_LAT = 2,
  parameter int unsigned LAT_W     = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  // incoming vga stream
  input  logic [10:0]      vii_vcount,
  input  logic [10:0]      vii_hcount,
  input  logic             vii_vsync,
  input  logic             vii_hsync,
  input  logic             vii_vblnk,
  input  logic             vii_hblnk,
  input  logic [11:0]      vii_rgb,
  // outgoing vga stream
  output logic [10:0]      vio_vcount,
  output logic [10:0]      vio_hcount,
  output logic             vio_vsync,
  output logic             vio_hsync,
  output logic             vio_vblnk,
  output logic             vio_hblnk,
  output logic [11:0]      vio_rgb,
  // latency configuration
  input  logic [LAT_W-1:0] cfg_lat,
  input  logic             cfg_req,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic [LAT_W-1:0] cur_lat,
  output logic             busy
);

  localparam int unsigned CntW = LAT_W + 1;
  localparam logic [LAT_W-1:0] MaxLat   = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] ResetLat = LAT_W'(RESET_LAT);

  typedef enum logic [1:0] {StIdle, StWaitFrame, StFlush, StAck} state_e;

  state_e            state_q;
  logic [LAT_W-1:0]  pend_q;
  logic [LAT_W-1:0]  cur_lat_q;
  logic [CntW-1:0]   cnt_q;
  logic              cfg_ack_q;
  logic              cfg_err_q;
  logic              busy_q;
  logic [11:0]       dly_q [MAX_LAT+1];
  logic [11:0]       rgb_tap;
  logic              force_zero;
  logic              fs;

  assign fs      = (vii_vcount == 11'd0) && (vii_hcount == 11'd0);
  assign cur_lat = cur_lat_q;
  assign cfg_ack = cfg_ack_q;
  assign cfg_err = cfg_err_q;
  assign busy    = busy_q;

  // Timing path: one register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vio_vcount <= '0;
      vio_hcount <= '0;
      vio_vsync  <= 1'b0;
      vio_hsync  <= 1'b0;
      vio_vblnk  <= 1'b0;
      vio_hblnk  <= 1'b0;
    end else begin
      vio_vcount <= vii_vcount;
      vio_hcount <= vii_hcount;
      vio_vsync  <= vii_vsync;
      vio_hsync  <= vii_hsync;
      vio_vblnk  <= vii_vblnk;
      vio_hblnk  <= vii_hblnk;
    end
  end

  // rgb delay line; stage k holds rgb delayed by k+1 cycles and never stops shifting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= int'(MAX_LAT); i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q[0] <= vii_rgb;
      for (int i = 1; i <= int'(MAX_LAT); i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  // Tap selection and output blanking.
  always_comb begin
    rgb_tap = '0;
    for (int i = 0; i <= int'(MAX_LAT); i++) begin
      if (cur_lat_q == LAT_W'(i)) begin
        rgb_tap = dly_q[i];
      end
    end
`ifdef RGB_LAT_CTRL_BLANK_EN
    force_zero = (state_q == StFlush) || vio_hblnk || vio_vblnk;
`else
    force_zero = (state_q == StFlush);
`endif
    vio_rgb = force_zero ? 12'd0 : rgb_tap;
  end

  // Configuration FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pend_q    <= '0;
      cur_lat_q <= ResetLat;
      cnt_q     <= '0;
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_req) begin
            pend_q    <= (cfg_lat > MaxLat) ? MaxLat : cfg_lat;
            cfg_err_q <= (cfg_lat > MaxLat);
            busy_q    <= 1'b1;
            state_q   <= StWaitFrame;
          end
        end
        StWaitFrame: begin
          // A request dropped early is still carried through to completion.
          if (fs) begin
            cur_lat_q <= pend_q;
            cnt_q     <= CntW'(pend_q) + CntW'(1);
            state_q   <= StFlush;
          end
        end
        StFlush: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            busy_q    <= 1'b0;
            cfg_ack_q <= cfg_req;
            state_q   <= StAck;
          end
        end
        StAck: begin
          if (!cfg_req) begin
            cfg_ack_q <= 1'b0;
            state_q   <= StIdle;
          end else begin
            cfg_ack_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_lat_ctrl.sv
// Directed bench for rgb_lat_ctrl on a small 16x8 frame.
module tb_rgb_lat_ctrl;

  localparam int unsigned LAT_W = 3;

  logic              clk;
  logic              rst;
  logic [10:0]       vii_vcount, vii_hcount;
  logic              vii_vsync, vii_hsync, vii_vblnk, vii_hblnk;
  logic [11:0]       vii_rgb;
  logic [10:0]       vio_vcount, vio_hcount;
  logic              vio_vsync, vio_hsync, vio_vblnk, vio_hblnk;
  logic [11:0]       vio_rgb;
  logic [LAT_W-1:0]  cfg_lat;
  logic              cfg_req;
  logic              cfg_ack;
  logic              cfg_err;
  logic [LAT_W-1:0]  cur_lat;
  logic              busy;

  rgb_lat_ctrl #(
    .MAX_LAT   (4),
    .RESET_LAT (2),
    .LAT_W     (LAT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vii_vcount (vii_vcount),
    .vii_hcount (vii_hcount),
    .vii_vsync  (vii_vsync),
    .vii_hsync  (vii_hsync),
    .vii_vblnk  (vii_vblnk),
    .vii_hblnk  (vii_hblnk),
    .vii_rgb    (vii_rgb),
    .vio_vcount (vio_vcount),
    .vio_hcount (vio_hcount),
    .vio_vsync  (vio_vsync),
    .vio_hsync  (vio_hsync),
    .vio_vblnk  (vio_vblnk),
    .vio_hblnk  (vio_hblnk),
    .vio_rgb    (vio_rgb),
    .cfg_lat    (cfg_lat),
    .cfg_req    (cfg_req),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .cur_lat    (cur_lat),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          h = 0;
  int          v = 0;
  int          pix = 0;
  int          mode = 0;   // 0: constant ABC, 1: ramp, 2: FFF in blanking else ramp
  int          cap_h = 0;
  int          cap_v = 0;
  logic        cap_hb = 1'b0;
  logic        cap_vb = 1'b0;
  logic [11:0] hist [8];   // hist[k]: rgb applied k edges ago (hist[0] not yet captured)

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    vii_hcount = 11'(h);
    vii_vcount = 11'(v);
    vii_hblnk  = (h >= 12);
    vii_vblnk  = (v >= 6);
    vii_hsync  = (h == 13) || (h == 14);
    vii_vsync  = (v == 7);
    case (mode)
      0:       vii_rgb = 12'hABC;
      1:       vii_rgb = 12'(pix);
      default: vii_rgb = (vii_hblnk || vii_vblnk) ? 12'hFFF : 12'(pix);
    endcase
    hist[0] = vii_rgb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cap_h  = h;
    cap_v  = v;
    cap_hb = vii_hblnk;
    cap_vb = vii_vblnk;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    pix++;
    h++;
    if (h == 16) begin
      h = 0;
      v = (v == 7) ? 0 : v + 1;
    end
    apply();
  endtask

  function automatic logic [11:0] exp_rgb(input int lat);
    logic [11:0] r;
    r = hist[lat+1];
`ifdef RGB_LAT_CTRL_BLANK_EN
    if (cap_hb || cap_vb) r = 12'd0;
`endif
    return r;
  endfunction

  // Returns when the applied pixel is frame start, so the next edge is the fs edge.
  task automatic wait_fs();
    int n;
    n = 0;
    while (!(h == 0 && v == 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("fs_timeout", 32'd0, 32'd1);
  endtask

  // Called with the fs edge next: flush of lat+1 blank cycles, ack, release.
  task automatic finish_cfg(input int lat);
    tick();
    check("fs_cur_lat", 32'(cur_lat), 32'(lat));
    check("fs_busy", 32'(busy), 32'd1);
    check("fs_vio_h", 32'(vio_hcount), 32'(cap_h));
    check("flush_rgb0", 32'(vio_rgb), 32'd0);
    for (int i = 1; i <= lat; i++) begin
      tick();
      check("flush_rgb", 32'(vio_rgb), 32'd0);
    end
    tick();
    check("ack_high", 32'(cfg_ack), 32'd1);
    check("ack_busy", 32'(busy), 32'd0);
    check("ack_rgb", 32'(vio_rgb), 32'(exp_rgb(lat)));
    cfg_req = 1'b0;
    tick();
    check("ack_low", 32'(cfg_ack), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rgb", 32'(vio_rgb), 32'(exp_rgb(lat)));
  endtask

  initial begin
    int n;
    for (int k = 0; k < 8; k++) hist[k] = 12'd0;
    cfg_req = 1'b0;
    cfg_lat = '0;
    rst = 1'b1;
    apply();
    #2 rst = 1'b0;
    #1;
    // 1: reset values and latency-3 start-up
    check("rst_rgb", 32'(vio_rgb), 32'd0);
    check("rst_cur_lat", 32'(cur_lat), 32'd2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(cfg_ack), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t1_rgb_e1", 32'(vio_rgb), 32'd0);
    check("t1_h_e1", 32'(vio_hcount), 32'(cap_h));
    tick();
    check("t1_rgb_e2", 32'(vio_rgb), 32'd0);
    tick();
    check("t1_rgb_e3", 32'(vio_rgb), 32'hABC);
    check("t1_cur_lat", 32'(cur_lat), 32'd2);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: mid-frame request for latency 4
    mode = 1;
    apply();
    n = 0;
    while (v != 3 && n < 300) begin
      tick();
      n++;
    end
    cfg_lat = 3'd4;
    cfg_req = 1'b1;
    tick();
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_err", 32'(cfg_err), 32'd0);
    check("t2_cur_lat_hold", 32'(cur_lat), 32'd2);
    check("t2_rgb_old_lat", 32'(vio_rgb), 32'(exp_rgb(2)));
    wait_fs();
    check("t2_cur_lat_pre_fs", 32'(cur_lat), 32'd2);
    check("t2_vsync", 32'(vio_vsync), 32'(cap_v == 7));
    finish_cfg(4);

    // 4: reset during flush
    cfg_lat = 3'd3;
    cfg_req = 1'b1;
    tick();
    wait_fs();
    tick();
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_cur_lat", 32'(cur_lat), 32'd3);
    tick();
    check("t4_vio_h_pre", 32'(vio_hcount), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t4_async_h", 32'(vio_hcount), 32'd0);
    check("t4_async_lat", 32'(cur_lat), 32'd2);
    check("t4_async_busy", 32'(busy), 32'd0);
    cfg_req = 1'b0;
    tick();
    tick();
    check("t4_no_ack", 32'(cfg_ack), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t4_no_ack_rel", 32'(cfg_ack), 32'd0);
    end
    check("t4_rgb_rel", 32'(vio_rgb), 32'(exp_rgb(2)));
    check("t4_h_rel", 32'(vio_hcount), 32'(cap_h));
    cfg_lat = 3'd0;
    cfg_req = 1'b1;
    tick();
    wait_fs();
    finish_cfg(0);

    // 3: out-of-range request clamps to 4
    cfg_lat = 3'd7;
    cfg_req = 1'b1;
    tick();
    check("t3_err_pulse", 32'(cfg_err), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    tick();
    check("t3_err_clear", 32'(cfg_err), 32'd0);
    wait_fs();
    check("t3_cur_lat_pre", 32'(cur_lat), 32'd0);
    finish_cfg(4);

    // 5: request raised on the fs cycle waits one frame
    wait_fs();
    cfg_lat = 3'd1;
    cfg_req = 1'b1;
    tick();
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_cur_lat_same", 32'(cur_lat), 32'd4);
    wait_fs();
    check("t5_cur_lat_pre", 32'(cur_lat), 32'd4);
    finish_cfg(1);

    // 6: FFF during blanking, latency 1
    mode = 2;
    apply();
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      check("t6_rgb", 32'(vio_rgb), 32'(exp_rgb(1)));
      check("t6_hblnk", 32'(vio_hblnk), 32'(cap_hb));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
